// File: rtl/l2_port_arbiter_pkg.sv
// l2_port_arbiter_pkg
//   Shared definitions for the L2 port arbiter: default bus widths, the
//   WAIT-state timeout default, the timeout counter width and the FSM
//   state encoding.
//   Optional feature macro: L2ARB_TIMEOUT_EN (used by l2_port_arbiter).
package l2_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF  = 32;
   localparam int unsigned DATA_W_DEF  = 512;
   localparam int unsigned DM_W_DEF    = DATA_W_DEF / 8;
   localparam int unsigned TIMEOUT_DEF = 4096;
   localparam int unsigned TO_CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/l2_port_arbiter_rr_pick.sv
// l2_port_arbiter_rr_pick
//   Combinational two-way round-robin picker.
//   Ports:
//     req       in   2   request vector, bit N = master N
//     last      in   1   index of the master granted last time
//     gnt_valid out  1   at least one request present
//     gnt_idx   out  1   index of the winning master
//   On a tie the master that did not win last time is chosen.
module l2_port_arbiter_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   assign gnt_valid = |req;
   // With a single requester req[1] is the answer; req[0]-only gives 0.
   assign gnt_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//   Shares one L2 Wishbone slave port between the D-cache (m0) and the
//   I-cache (m1). Round-robin grant, one L2 transaction in flight. The
//   winner's request is registered onto l2_*, the strobe is held until
//   l2_ack, and read data plus a one-cycle ack go back to the winner only.
//   Optional feature macro: L2ARB_TIMEOUT_EN -- when defined, a WAIT state
//   lasting TIMEOUT_CYCLES without l2_ack completes the transaction with
//   mN_err set and mN_dout cleared; when undefined mN_err is constant 0.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     mN_addr/din/dm/we/stb  (N=0,1)  master request inputs
//     mN_ack/dout/err                 master response outputs
//     l2_addr/din/dm/we/stb           registered request to L2
//     l2_ack, l2_dout                 L2 response
//     busy                            FSM not in IDLE
//     grant                           index of current/last granted master
module l2_port_arbiter
   import l2_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned DM_W           = DM_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_din,
   input  logic [DM_W-1:0]   m0_dm,
   input  logic              m0_we,
   input  logic              m0_stb,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_dout,
   output logic              m0_err,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_din,
   input  logic [DM_W-1:0]   m1_dm,
   input  logic              m1_we,
   input  logic              m1_stb,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_dout,
   output logic              m1_err,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [DATA_W-1:0] l2_din,
   output logic [DM_W-1:0]   l2_dm,
   output logic              l2_we,
   output logic              l2_stb,
   input  logic              l2_ack,
   input  logic [DATA_W-1:0] l2_dout,
   output logic              busy,
   output logic              grant
);

   arb_state_t state;
   logic       stb_q;
   logic       pick_valid;
   logic       pick_idx;

   l2_port_arbiter_rr_pick u_rr_pick (
      .req       ({m1_stb, m0_stb}),
      .last      (grant),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   // The FSM leaves WAIT on the same edge that samples l2_ack, so masking
   // the strobe with l2_ack keeps L2 from seeing a second request cycle.
   assign l2_stb = stb_q & ~l2_ack;
   assign busy   = (state != IDLE);

`ifdef L2ARB_TIMEOUT_EN
   logic [TO_CNT_W-1:0] to_cnt;
   logic                to_hit;

   assign to_hit = (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

   assign m0_err = 1'b0;
   assign m1_err = 1'b0;
`endif

   // NOTE: every register here is state, so all assignments are
   // non-blocking; blocking ones would let later statements observe
   // this cycle's updates and break the one-edge pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         stb_q   <= 1'b0;
         grant   <= 1'b1;
         l2_addr <= '0;
         l2_din  <= '0;
         l2_dm   <= '0;
         l2_we   <= 1'b0;
         m0_ack  <= 1'b0;
         m1_ack  <= 1'b0;
         m0_dout <= '0;
         m1_dout <= '0;
`ifdef L2ARB_TIMEOUT_EN
         m0_err  <= 1'b0;
         m1_err  <= 1'b0;
         to_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant <= pick_idx;
                  stb_q <= 1'b1;
                  state <= WAIT;
`ifdef L2ARB_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                  if (pick_idx) begin
                     l2_addr <= m1_addr;
                     l2_din  <= m1_din;
                     l2_dm   <= m1_dm;
                     l2_we   <= m1_we;
                  end else begin
                     l2_addr <= m0_addr;
                     l2_din  <= m0_din;
                     l2_dm   <= m0_dm;
                     l2_we   <= m0_we;
                  end
               end
            end

            WAIT: begin
               if (l2_ack) begin
                  stb_q <= 1'b0;
                  state <= RESP;
                  if (grant) begin
                     m1_dout <= l2_dout;
                     m1_ack  <= 1'b1;
                  end else begin
                     m0_dout <= l2_dout;
                     m0_ack  <= 1'b1;
                  end
               end
`ifdef L2ARB_TIMEOUT_EN
               else if (to_hit) begin
                  stb_q <= 1'b0;
                  state <= RESP;
                  if (grant) begin
                     m1_dout <= '0;
                     m1_ack  <= 1'b1;
                     m1_err  <= 1'b1;
                  end else begin
                     m0_dout <= '0;
                     m0_ack  <= 1'b1;
                     m0_err  <= 1'b1;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end

            RESP: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
`ifdef L2ARB_TIMEOUT_EN
               m0_err <= 1'b0;
               m1_err <= 1'b0;
`endif
               state  <= IDLE;
            end

            default: begin
               stb_q <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
